// File: rtl/axi_burst_responder_if.sv
// AXI4 bus bundle for axi_burst_responder: full AW/W/B/AR/R channel set.
// The slave modport is the responder's view; master is the traffic source.
interface axi_burst_responder_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 128,
    parameter int ID_WIDTH   = 4
);
    logic                    awvalid, awready;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic [ID_WIDTH-1:0]     awid;
    logic                    wvalid, wready, wlast;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    bvalid, bready;
    logic [1:0]              bresp;
    logic [ID_WIDTH-1:0]     bid;
    logic                    arvalid, arready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic [ID_WIDTH-1:0]     arid;
    logic                    rvalid, rready, rlast;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic [ID_WIDTH-1:0]     rid;

    modport slave (
        input  awvalid, awaddr, awlen, awsize, awburst, awid,
        output awready,
        input  wvalid, wdata, wstrb, wlast,
        output wready,
        output bvalid, bresp, bid,
        input  bready,
        input  arvalid, araddr, arlen, arsize, arburst, arid,
        output arready,
        output rvalid, rdata, rresp, rlast, rid,
        input  rready
    );

    modport master (
        output awvalid, awaddr, awlen, awsize, awburst, awid,
        input  awready,
        output wvalid, wdata, wstrb, wlast,
        input  wready,
        input  bvalid, bresp, bid,
        output bready,
        output arvalid, araddr, arlen, arsize, arburst, arid,
        input  arready,
        input  rvalid, rdata, rresp, rlast, rid,
        output rready
    );
endinterface

// File: rtl/axi_burst_responder.sv
// Single-burst AXI4 INCR slave backed by an on-chip word RAM.
// Define AXI_RESP_WSTRB_EN to honour wstrb per byte lane; otherwise writes are full-word.
module axi_burst_responder #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 128,
    parameter int                    ID_WIDTH   = 4,
    parameter int                    MEM_DEPTH  = 4096,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input logic                  clk,
    input logic                  rst,
    axi_burst_responder_if.slave axi
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFFS  = $clog2(BYTES);
    localparam int MIDX  = $clog2(MEM_DEPTH);
    localparam logic [2:0]          SIZE_OK = 3'(OFFS);
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(MEM_DEPTH);

    typedef enum logic [1:0] {IDLE, WDATA, WRESP, RDATA} state_t;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    state_t                state_q;
    logic                  last_was_write_q, awready_q, arready_q, wready_q, bvalid_q;
    logic                  rvalid_q, rlast_q, sk_valid_q, sk_last_q, desc_err_q, base_ok_q;
    logic [1:0]            bresp_q, rresp_q, sk_resp_q, err_q;
    logic [ID_WIDTH-1:0]   id_q;
    logic [7:0]            len_q;
    logic [8:0]            beat_q;  // writes: next beat to accept; reads: next beat to fetch
    logic [ADDR_WIDTH-1:0] idx_q;
    logic [DATA_WIDTH-1:0] rdata_q, sk_data_q;

    logic                  aw_take, ar_take, a_derr, w_fire, r_fire, fetch;
    logic                  beat_bad, last_beat, wr_en;
    logic [ADDR_WIDTH-1:0] a_addr, a_idx;
    logic [7:0]            a_len;
    logic [ID_WIDTH-1:0]   a_id;
    logic [ADDR_WIDTH:0]   word;
    logic [1:0]            beat_resp, err_d;
    logic [DATA_WIDTH-1:0] f_data;

    always_comb begin
        // On a tie the channel not served last wins
        aw_take = (state_q == IDLE) && axi.awvalid && awready_q &&
                  (!axi.arvalid || !last_was_write_q);
        ar_take = (state_q == IDLE) && axi.arvalid && arready_q && !aw_take;
        a_addr  = aw_take ? axi.awaddr : axi.araddr;
        a_len   = aw_take ? axi.awlen  : axi.arlen;
        a_id    = aw_take ? axi.awid   : axi.arid;
        a_derr  = aw_take ? (axi.awsize != SIZE_OK || axi.awburst != 2'b01)
                          : (axi.arsize != SIZE_OK || axi.arburst != 2'b01);
        a_idx   = (a_addr - BASE_ADDR) >> OFFS;

        word      = {1'b0, idx_q} + {{(ADDR_WIDTH-8){1'b0}}, beat_q};
        beat_bad  = !base_ok_q || (word >= DEPTH_W);
        beat_resp = beat_bad ? 2'b11 : (desc_err_q ? 2'b10 : 2'b00);
        last_beat = (beat_q == {1'b0, len_q});

        w_fire = (state_q == WDATA) && axi.wvalid && wready_q;
        wr_en  = w_fire && !beat_bad && !desc_err_q && !rst;
        err_d  = err_q;
        if (beat_resp > err_d) err_d = beat_resp;
        if ((axi.wlast != last_beat) && (err_d == 2'b00)) err_d = 2'b10;

        r_fire = (state_q == RDATA) && rvalid_q && axi.rready;
        // Prefetch while a slot will be free after this cycle's pop
        fetch  = (state_q == RDATA) && (beat_q <= {1'b0, len_q}) && !(sk_valid_q && !r_fire);
        f_data = (beat_bad || desc_err_q) ? '0 : mem[word[MIDX-1:0]];
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
`ifdef AXI_RESP_WSTRB_EN
            for (int b = 0; b < BYTES; b++)
                if (axi.wstrb[b]) mem[word[MIDX-1:0]][b*8 +: 8] <= axi.wdata[b*8 +: 8];
`else
            mem[word[MIDX-1:0]] <= axi.wdata;
`endif
        end
    end

`ifndef AXI_RESP_WSTRB_EN
    logic unused_wstrb;
    assign unused_wstrb = ^axi.wstrb;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            last_was_write_q <= 1'b0;
            awready_q        <= 1'b0;
            arready_q        <= 1'b0;
            wready_q         <= 1'b0;
            bvalid_q         <= 1'b0;
            bresp_q          <= 2'b00;
            rvalid_q         <= 1'b0;
            rlast_q          <= 1'b0;
            rresp_q          <= 2'b00;
            rdata_q          <= '0;
            sk_valid_q       <= 1'b0;
            sk_last_q        <= 1'b0;
            sk_resp_q        <= 2'b00;
            sk_data_q        <= '0;
            id_q             <= '0;
            len_q            <= '0;
            beat_q           <= '0;
            idx_q            <= '0;
            desc_err_q       <= 1'b0;
            base_ok_q        <= 1'b0;
            err_q            <= 2'b00;
        end else begin
            case (state_q)
                IDLE: begin
                    awready_q <= 1'b1;
                    arready_q <= 1'b1;
                    if (aw_take || ar_take) begin
                        awready_q        <= 1'b0;
                        arready_q        <= 1'b0;
                        last_was_write_q <= aw_take;
                        id_q             <= a_id;
                        len_q            <= a_len;
                        beat_q           <= '0;
                        idx_q            <= a_idx;
                        base_ok_q        <= (a_addr >= BASE_ADDR);
                        desc_err_q       <= a_derr;
                        err_q            <= a_derr ? 2'b10 : 2'b00;
                        wready_q         <= aw_take;
                        state_q          <= aw_take ? WDATA : RDATA;
                    end
                end
                WDATA: begin
                    if (w_fire) begin
                        beat_q <= beat_q + 9'd1;
                        err_q  <= err_d;
                        if (last_beat) begin
                            wready_q <= 1'b0;
                            bvalid_q <= 1'b1;
                            bresp_q  <= err_d;
                            state_q  <= WRESP;
                        end
                    end
                end
                WRESP: begin
                    if (axi.bready) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        arready_q <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                RDATA: begin
                    if (fetch) beat_q <= beat_q + 9'd1;
                    if (r_fire) begin
                        rvalid_q <= sk_valid_q || fetch;
                        if (sk_valid_q) begin
                            rdata_q    <= sk_data_q;
                            rresp_q    <= sk_resp_q;
                            rlast_q    <= sk_last_q;
                            sk_valid_q <= fetch;
                            if (fetch) begin
                                sk_data_q <= f_data;
                                sk_resp_q <= beat_resp;
                                sk_last_q <= last_beat;
                            end
                        end else if (fetch) begin
                            rdata_q <= f_data;
                            rresp_q <= beat_resp;
                            rlast_q <= last_beat;
                        end
                    end else if (!rvalid_q) begin
                        rvalid_q <= fetch;
                        if (fetch) begin
                            rdata_q <= f_data;
                            rresp_q <= beat_resp;
                            rlast_q <= last_beat;
                        end
                    end else if (fetch) begin
                        sk_valid_q <= 1'b1;
                        sk_data_q  <= f_data;
                        sk_resp_q  <= beat_resp;
                        sk_last_q  <= last_beat;
                    end
                    if (r_fire && rlast_q) begin
                        rvalid_q   <= 1'b0;
                        sk_valid_q <= 1'b0;
                        awready_q  <= 1'b1;
                        arready_q  <= 1'b1;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign axi.awready = awready_q;
    assign axi.arready = arready_q;
    assign axi.wready  = wready_q;
    assign axi.bvalid  = bvalid_q;
    assign axi.bresp   = bresp_q;
    assign axi.bid     = id_q;
    assign axi.rvalid  = rvalid_q;
    assign axi.rdata   = rdata_q;
    assign axi.rresp   = rresp_q;
    assign axi.rlast   = rlast_q;
    assign axi.rid     = id_q;
endmodule
